// File: rtl/sdram_arbiter_pkg.sv
// Shared SDRAM command encodings, arbiter state encoding and burst defaults
// used by the arbiter and its burst tracker.
package sdram_arbiter_pkg;

    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_TURN = 2'd2;

    localparam int SDRAM_READ_BURST_LENGTH = 8;

    // Only READ and WRITE start a real burst; NOP and 2'b11 complete at once.
    function automatic logic isBurstCmd(input logic [1:0] cmd);
        return (cmd == CMD_READ) || (cmd == CMD_WRITE);
    endfunction

endpackage

// File: rtl/sdram_arbiter_burst_tracker.sv
// Beat counter and completion detect for one granted SDRAM burst; strobes
// must already be qualified by the caller's busy state.
module burst_tracker
    import sdram_arbiter_pkg::*;
#(
    parameter int READ_BURST_LENGTH = SDRAM_READ_BURST_LENGTH
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Start,
    input  logic i_Is_Read,
    input  logic i_Read_Valid,
    input  logic i_Write_Done,
    output logic o_Complete
);

    localparam int CW = $clog2(READ_BURST_LENGTH + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(READ_BURST_LENGTH - 1);

    logic [CW-1:0] r_Beat_Count;

    always_ff @(posedge i_Clk) begin
        if (i_Reset || i_Start) begin
            r_Beat_Count <= '0;
        end else if (i_Is_Read && i_Read_Valid) begin
            r_Beat_Count <= r_Beat_Count + CW'(1);
        end
    end

    // Wrong-type strobes fall out here: a read ignores write-done and vice versa.
    assign o_Complete = i_Is_Read ? (i_Read_Valid && (r_Beat_Count == LAST_BEAT))
                                  : i_Write_Done;

endmodule

// File: rtl/sdram_arbiter.sv
// Two-port arbiter in front of the as4c4m32s controller: port 0 display refill,
// port 1 fractal writer. Define SDRAM_ARB_STARVE_GUARD_EN to build the port-1 starve guard.
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int READ_BURST_LENGTH = SDRAM_READ_BURST_LENGTH,
    parameter int STARVE_LIMIT      = 4
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic        i_Req0,
    input  logic        i_Req1,
    input  logic [1:0]  i_Command0,
    input  logic [1:0]  i_Command1,
    input  logic [21:0] i_Address0,
    input  logic [21:0] i_Address1,
    input  logic [31:0] i_Write_Data0,
    input  logic [31:0] i_Write_Data1,
    output logic [1:0]  o_Command,
    output logic [21:0] o_Data_Address,
    output logic [31:0] o_Data_Write,
    input  logic        i_Data_Read_Valid,
    input  logic        i_Data_Write_Done,
    output logic [1:0]  o_Grant,
    output logic        o_Read_Valid0,
    output logic        o_Read_Valid1,
    output logic        o_Done0,
    output logic        o_Done1
);

    logic [1:0]  r_State;
    logic [1:0]  r_Command;
    logic [21:0] r_Address;
    logic [1:0]  r_Grant;
    logic        r_Done0;
    logic        r_Done1;

    logic        w_Idle;
    logic        w_Busy;
    logic        w_Any_Req;
    logic        w_Starve;
    logic        w_Pick1;
    logic [1:0]  w_Win_Cmd;
    logic [21:0] w_Win_Addr;
    logic        w_Start;
    logic        w_Complete;

    assign w_Idle     = (r_State == ST_IDLE);
    assign w_Busy     = (r_State == ST_BUSY);
    assign w_Any_Req  = i_Req0 | i_Req1;
    assign w_Pick1    = i_Req1 && (!i_Req0 || w_Starve);
    assign w_Win_Cmd  = w_Pick1 ? i_Command1 : i_Command0;
    assign w_Win_Addr = w_Pick1 ? i_Address1 : i_Address0;
    assign w_Start    = w_Idle && w_Any_Req && isBurstCmd(w_Win_Cmd);

`ifdef SDRAM_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] r_Starve_Cnt;

    assign w_Starve = (r_Starve_Cnt == SW'(STARVE_LIMIT)) && i_Req1;

    // Counts port-0 wins that made a waiting port 1 lose; any other grant clears it.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_Starve_Cnt <= '0;
        end else if (w_Idle && w_Any_Req) begin
            if (w_Pick1 || !i_Req1) begin
                r_Starve_Cnt <= '0;
            end else if (r_Starve_Cnt != SW'(STARVE_LIMIT)) begin
                r_Starve_Cnt <= r_Starve_Cnt + SW'(1);
            end
        end
    end
`else
    assign w_Starve = 1'b0;
`endif

    burst_tracker #(
        .READ_BURST_LENGTH(READ_BURST_LENGTH)
    ) u_Tracker (
        .i_Clk        (i_Clk),
        .i_Reset      (i_Reset),
        .i_Start      (w_Start),
        .i_Is_Read    (r_Command == CMD_READ),
        .i_Read_Valid (i_Data_Read_Valid && w_Busy),
        .i_Write_Done (i_Data_Write_Done && w_Busy),
        .o_Complete   (w_Complete)
    );

    // Done pulses land in the TURN cycle, where command is already NOP and grant cleared.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_State   <= ST_IDLE;
            r_Command <= CMD_NOP;
            r_Address <= '0;
            r_Grant   <= 2'b00;
            r_Done0   <= 1'b0;
            r_Done1   <= 1'b0;
        end else begin
            r_Done0 <= 1'b0;
            r_Done1 <= 1'b0;
            case (r_State)
                ST_IDLE: begin
                    if (w_Any_Req) begin
                        if (isBurstCmd(w_Win_Cmd)) begin
                            r_State   <= ST_BUSY;
                            r_Command <= w_Win_Cmd;
                            r_Address <= w_Win_Addr;
                            r_Grant   <= w_Pick1 ? 2'b10 : 2'b01;
                        end else begin
                            r_State <= ST_TURN;
                            r_Done0 <= !w_Pick1;
                            r_Done1 <= w_Pick1;
                        end
                    end
                end
                ST_BUSY: begin
                    if (w_Complete) begin
                        r_State   <= ST_TURN;
                        r_Command <= CMD_NOP;
                        r_Grant   <= 2'b00;
                        r_Done0   <= r_Grant[0];
                        r_Done1   <= r_Grant[1];
                    end
                end
                ST_TURN: begin
                    r_State <= ST_IDLE;
                end
                default: begin
                    r_State   <= ST_IDLE;
                    r_Command <= CMD_NOP;
                    r_Grant   <= 2'b00;
                end
            endcase
        end
    end

    always_comb begin
        o_Data_Write = '0;
        case (r_Grant)
            2'b01:   o_Data_Write = i_Write_Data0;
            2'b10:   o_Data_Write = i_Write_Data1;
            default: o_Data_Write = '0;
        endcase
    end

    assign o_Command      = r_Command;
    assign o_Data_Address = r_Address;
    assign o_Grant        = r_Grant;
    assign o_Done0        = r_Done0;
    assign o_Done1        = r_Done1;
    assign o_Read_Valid0  = i_Data_Read_Valid & r_Grant[0];
    assign o_Read_Valid1  = i_Data_Read_Valid & r_Grant[1];

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: directed scenarios plus randomized
// request rounds scored against a transaction-level arbitration model.
module tb_sdram_arbiter;
    import sdram_arbiter_pkg::*;

    localparam int RBL   = 8;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [1:0]  cmd0, cmd1;
    logic [21:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        rv, wd;
    logic [1:0]  o_Command;
    logic [21:0] o_Data_Address;
    logic [31:0] o_Data_Write;
    logic [1:0]  o_Grant;
    logic        o_Read_Valid0, o_Read_Valid1, o_Done0, o_Done1;

    int total = 0;
    int bad   = 0;
    int modelStarve = 0;

    always #5 clk = ~clk;

    sdram_arbiter #(
        .READ_BURST_LENGTH(RBL),
        .STARVE_LIMIT     (LIMIT)
    ) dut (
        .i_Clk            (clk),
        .i_Reset          (reset),
        .i_Req0           (req0),
        .i_Req1           (req1),
        .i_Command0       (cmd0),
        .i_Command1       (cmd1),
        .i_Address0       (addr0),
        .i_Address1       (addr1),
        .i_Write_Data0    (wdata0),
        .i_Write_Data1    (wdata1),
        .o_Command        (o_Command),
        .o_Data_Address   (o_Data_Address),
        .o_Data_Write     (o_Data_Write),
        .i_Data_Read_Valid(rv),
        .i_Data_Write_Done(wd),
        .o_Grant          (o_Grant),
        .o_Read_Valid0    (o_Read_Valid0),
        .o_Read_Valid1    (o_Read_Valid1),
        .o_Done0          (o_Done0),
        .o_Done1          (o_Done1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int port, input logic [1:0] cmd, input logic [21:0] addr, input logic [31:0] data);
        if (port == 0) begin
            req0 = 1'b1; cmd0 = cmd; addr0 = addr; wdata0 = data;
        end else begin
            req1 = 1'b1; cmd1 = cmd; addr1 = addr; wdata1 = data;
        end
    endtask

    task automatic dropReq(input int port);
        if (port == 0) req0 = 1'b0;
        else           req1 = 1'b0;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #2;
    endtask

    // Arbitration rules: port 0 by default, port 1 when alone or when starved.
    function automatic int modelWinner(input bit r0, input bit r1);
`ifdef SDRAM_ARB_STARVE_GUARD_EN
        if (r1 && (!r0 || modelStarve >= LIMIT)) return 1;
`else
        if (r1 && !r0) return 1;
`endif
        return 0;
    endfunction

    task automatic modelUpdate(input int winner, input bit r1);
        if (winner == 1 || !r1) modelStarve = 0;
        else if (modelStarve < LIMIT) modelStarve++;
    endtask

    task automatic idleCycle(input string tag);
        stepCycle();
        checkOutput({tag, ".idle_grant"}, 32'(o_Grant), 32'(2'b00));
        checkOutput({tag, ".idle_done"}, 32'({o_Done1, o_Done0}), 32'(2'b00));
    endtask

    // Called just after the grant edge; plays the controller until the done pulse.
    task automatic serviceBurst(input int port, input logic [1:0] cmd, input logic [21:0] addr,
                                input logic [31:0] data, input int dropBeat, input bit spurious,
                                input string tag);
        logic [1:0] expGrant;
        int  beats;
        int  budget;
        bit  finished;
        expGrant = (port == 0) ? 2'b01 : 2'b10;
        beats    = 0;
        budget   = 0;
        finished = 1'b0;
        checkOutput({tag, ".grant"}, 32'(o_Grant), 32'(expGrant));
        checkOutput({tag, ".cmd"}, 32'(o_Command), 32'(cmd));
        checkOutput({tag, ".addr"}, 32'(o_Data_Address), 32'(addr));
        while (!finished && budget < 64) begin
            budget++;
            rv = 1'b0;
            wd = 1'b0;
            if (cmd == CMD_READ) begin
                if ($urandom_range(0, 3) != 0) rv = 1'b1;
                if (spurious && !rv) wd = 1'b1;
            end else begin
                if ($urandom_range(0, 2) == 0) wd = 1'b1;
            end
            #1;
            checkOutput({tag, ".rv0"}, 32'(o_Read_Valid0), 32'(rv && port == 0));
            checkOutput({tag, ".rv1"}, 32'(o_Read_Valid1), 32'(rv && port == 1));
            checkOutput({tag, ".wdata"}, o_Data_Write, data);
            stepCycle();
            if (rv) beats++;
            if (cmd == CMD_READ) finished = (beats == RBL);
            else                 finished = wd;
            rv = 1'b0;
            wd = 1'b0;
            if (beats == dropBeat) dropReq(port);
            checkOutput({tag, ".done0"}, 32'(o_Done0), 32'(finished && port == 0));
            checkOutput({tag, ".done1"}, 32'(o_Done1), 32'(finished && port == 1));
        end
        if (!finished) checkOutput({tag, ".timeout"}, 32'(0), 32'(1));
        checkOutput({tag, ".turn_grant"}, 32'(o_Grant), 32'(2'b00));
        checkOutput({tag, ".turn_cmd"}, 32'(o_Command), 32'(CMD_NOP));
        dropReq(port);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         expSeq[10];
        logic [21:0] curAddr[2];
        logic [31:0] curData[2];
        logic [1:0]  curCmd[2];
        bit          pending[2];
        int          w;

        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        cmd0 = CMD_NOP; cmd1 = CMD_NOP;
        addr0 = '0; addr1 = '0;
        wdata0 = 32'hA5A5_A5A5; wdata1 = 32'h5A5A_5A5A;
        rv = 1'b1; wd = 1'b0;

        // Reset state
        stepCycle();
        stepCycle();
        checkOutput("reset.cmd", 32'(o_Command), 32'(CMD_NOP));
        checkOutput("reset.addr", 32'(o_Data_Address), 32'(0));
        checkOutput("reset.grant", 32'(o_Grant), 32'(0));
        checkOutput("reset.done", 32'({o_Done1, o_Done0}), 32'(0));
        checkOutput("reset.wdata", o_Data_Write, 32'(0));
        checkOutput("reset.rv", 32'({o_Read_Valid1, o_Read_Valid0}), 32'(0));
        rv = 1'b0;
        reset = 1'b0;
        modelStarve = 0;

        // Port 0 alone, read burst
        applyStimulus(0, CMD_READ, 22'h000100, 32'h1111_2222);
        stepCycle();
        serviceBurst(0, CMD_READ, 22'h000100, 32'h1111_2222, -1, 1'b0, "p0read");
        modelUpdate(0, 1'b0);
        idleCycle("p0read");

        // Port 1 alone, write burst at the top address
        applyStimulus(1, CMD_WRITE, 22'h3FFFFF, 32'hDEADBEEF);
        stepCycle();
        serviceBurst(1, CMD_WRITE, 22'h3FFFFF, 32'hDEADBEEF, -1, 1'b0, "p1write");
        modelUpdate(1, 1'b1);
        idleCycle("p1write");

        // Read-valid in IDLE is ignored, then a read with spurious write-done strobes
        rv = 1'b1;
        #1;
        checkOutput("idle_rv.rv", 32'({o_Read_Valid1, o_Read_Valid0}), 32'(0));
        stepCycle();
        rv = 1'b0;
        checkOutput("idle_rv.done", 32'({o_Done1, o_Done0}), 32'(0));
        checkOutput("idle_rv.grant", 32'(o_Grant), 32'(0));
        applyStimulus(0, CMD_READ, 22'h0ABCDE, 32'h0);
        stepCycle();
        serviceBurst(0, CMD_READ, 22'h0ABCDE, 32'h0, -1, 1'b1, "spurious");
        modelUpdate(0, 1'b0);
        idleCycle("spurious");

        // Requester drops its request after beat 2
        applyStimulus(0, CMD_READ, 22'h001000, 32'h7777_0000);
        stepCycle();
        serviceBurst(0, CMD_READ, 22'h001000, 32'h7777_0000, 2, 1'b0, "drop");
        modelUpdate(0, 1'b0);
        idleCycle("drop");

        // Illegal command completes at once and issues nothing
        applyStimulus(0, 2'b11, 22'h000055, 32'h0);
        stepCycle();
        checkOutput("illegal.grant", 32'(o_Grant), 32'(0));
        checkOutput("illegal.cmd", 32'(o_Command), 32'(CMD_NOP));
        checkOutput("illegal.done0", 32'(o_Done0), 32'(1));
        checkOutput("illegal.done1", 32'(o_Done1), 32'(0));
        dropReq(0);
        modelUpdate(0, 1'b0);
        idleCycle("illegal");

        // Reset at read beat 3 aborts; a fresh request then runs normally
        applyStimulus(0, CMD_READ, 22'h002000, 32'h0);
        stepCycle();
        checkOutput("rstmid.grant", 32'(o_Grant), 32'(2'b01));
        for (int i = 0; i < 2; i++) begin
            rv = 1'b1;
            stepCycle();
        end
        rv = 1'b1;
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
        rv = 1'b0;
        modelStarve = 0;
        checkOutput("rstmid.cmd", 32'(o_Command), 32'(CMD_NOP));
        checkOutput("rstmid.grant0", 32'(o_Grant), 32'(0));
        checkOutput("rstmid.done", 32'({o_Done1, o_Done0}), 32'(0));
        applyStimulus(0, CMD_READ, 22'h002040, 32'h0);
        stepCycle();
        serviceBurst(0, CMD_READ, 22'h002040, 32'h0, -1, 1'b0, "rstfresh");
        modelUpdate(0, 1'b0);
        idleCycle("rstfresh");

        // Both ports requesting continuously
`ifdef SDRAM_ARB_STARVE_GUARD_EN
        expSeq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`else
        expSeq = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif
        for (int p = 0; p < 2; p++) begin
            curAddr[p] = 22'($urandom);
            curData[p] = $urandom;
            applyStimulus(p, CMD_WRITE, curAddr[p], curData[p]);
        end
        for (int i = 0; i < 10; i++) begin
            w = expSeq[i];
            stepCycle();
            serviceBurst(w, CMD_WRITE, curAddr[w], curData[w], -1, 1'b0, $sformatf("fair%0d", i));
            modelUpdate(w, 1'b1);
            curAddr[w] = 22'($urandom);
            curData[w] = $urandom;
            applyStimulus(w, CMD_WRITE, curAddr[w], curData[w]);
            idleCycle($sformatf("fair%0d", i));
        end
        req0 = 1'b0;
        req1 = 1'b0;

        // Randomized request rounds against the arbitration model
        pending[0] = 1'b0;
        pending[1] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pending[p] && $urandom_range(0, 1) == 1) pending[p] = 1'b1;
            end
            if (!pending[0] && !pending[1]) pending[$urandom_range(0, 1)] = 1'b1;
            for (int p = 0; p < 2; p++) begin
                if (pending[p] && !(p == 0 ? req0 : req1)) begin
                    curCmd[p]  = ($urandom_range(0, 1) == 1) ? CMD_READ : CMD_WRITE;
                    curAddr[p] = 22'($urandom);
                    curData[p] = $urandom;
                    applyStimulus(p, curCmd[p], curAddr[p], curData[p]);
                end
            end
            w = modelWinner(pending[0], pending[1]);
            modelUpdate(w, pending[1]);
            stepCycle();
            serviceBurst(w, curCmd[w], curAddr[w], curData[w], -1, 1'($urandom_range(0, 1)),
                         $sformatf("rand%0d", i));
            pending[w] = 1'b0;
            idleCycle($sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
